sensor_pwr_seq: RTL and testbench

Power-up/power-down sequencer for the CMOS sensor interface. It generates the clock-enable that drives the sensor master-clock forwarding stage (ODDR2-based, `ce` input). It also generates the sensor reset and a ready flag that releases the SPI configuration and readout logic. All timing is counted in the same global clock that the forwarding stage outputs, so `clk_ce` is glitch-free and aligned at the pin.

---
 rtl/sensor_pkg.sv | 47 ++++
 rtl/seq_delay_cnt.sv | 29 ++
 rtl/sensor_pwr_seq.sv | 134 +++++++++++++
 tb/tb_sensor_pwr_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared definitions for the CMOS sensor power sequencer: state codes,
// GVISION200 default timing and the per-state output decode.
package sensor_pkg;

    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_PWR   = 3'd1;
    localparam logic [2:0] ST_CLK   = 3'd2;
    localparam logic [2:0] ST_RST   = 3'd3;
    localparam logic [2:0] ST_READY = 3'd4;
    localparam logic [2:0] ST_STOP  = 3'd5;

    localparam int unsigned DEF_T_PWR     = 32'd1000;
    localparam int unsigned DEF_T_CLK2RST = 32'd100;
    localparam int unsigned DEF_T_RST2RDY = 32'd2000;
    localparam int unsigned DEF_T_STOP    = 32'd16;
    localparam int unsigned DEF_CNT_W     = 32'd16;

    // The master clock runs whenever the sensor may be out of reset or is being put back into it
    function automatic logic st_clk_ce(input logic [2:0] st);
        case (st)
            ST_CLK, ST_RST, ST_READY, ST_STOP: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic logic st_rst_n(input logic [2:0] st);
        case (st)
            ST_RST, ST_READY: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic st_ready(input logic [2:0] st);
        case (st)
            ST_READY: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic st_busy(input logic [2:0] st);
        case (st)
            ST_OFF, ST_READY: return 1'b0;
            default:          return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/seq_delay_cnt.sv
// Loadable down-counter that parks at zero; shared with the readout timing blocks.
module seq_delay_cnt #(
    parameter int unsigned CNT_W = 32'd16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Load wins over counting; the count holds once it reaches zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/sensor_pwr_seq.sv
// Sensor power-up/power-down sequencer: drives the master-clock enable, the
// sensor reset pin and the ready flag that releases configuration logic.
module sensor_pwr_seq
    import sensor_pkg::*;
#(
    parameter int unsigned T_PWR     = DEF_T_PWR,
    parameter int unsigned T_CLK2RST = DEF_T_CLK2RST,
    parameter int unsigned T_RST2RDY = DEF_T_RST2RDY,
    parameter int unsigned T_STOP    = DEF_T_STOP,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       clk_ce,
    output logic       sensor_rst_n,
    output logic       sensor_ready,
    output logic       busy,
    output logic [2:0] seq_state
);

    // A timed state lasting T cycles starts its count at T-1 and leaves when it reads zero
    localparam logic [CNT_W-1:0] LD_PWR  = CNT_W'(T_PWR - 32'd1);
    localparam logic [CNT_W-1:0] LD_CLK  = CNT_W'(T_CLK2RST - 32'd1);
    localparam logic [CNT_W-1:0] LD_RST  = CNT_W'(T_RST2RDY - 32'd1);
    localparam logic [CNT_W-1:0] LD_STOP = CNT_W'(T_STOP - 32'd1);

    logic [2:0]       state_r;
    logic [2:0]       next_state_s;
    logic             load_s;
    logic [CNT_W-1:0] load_val_s;
    logic             zero_s;

    seq_delay_cnt #(
        .CNT_W (CNT_W)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_val (load_val_s),
        .zero     (zero_s)
    );

    // Next-state selection; en low aborts before reset release, otherwise reset goes first
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        load_val_s   = {CNT_W{1'b0}};
        case (state_r)
            ST_OFF: begin
                if (en) begin
                    next_state_s = ST_PWR;
                    load_s       = 1'b1;
                    load_val_s   = LD_PWR;
                end else begin
                    next_state_s = ST_OFF;
                end
            end
            ST_PWR: begin
                if (!en) begin
                    next_state_s = ST_OFF;
                end else if (zero_s) begin
                    next_state_s = ST_CLK;
                    load_s       = 1'b1;
                    load_val_s   = LD_CLK;
                end else begin
                    next_state_s = ST_PWR;
                end
            end
            ST_CLK: begin
                if (!en) begin
                    next_state_s = ST_OFF;
                end else if (zero_s) begin
                    next_state_s = ST_RST;
                    load_s       = 1'b1;
                    load_val_s   = LD_RST;
                end else begin
                    next_state_s = ST_CLK;
                end
            end
            ST_RST: begin
                if (!en) begin
                    next_state_s = ST_STOP;
                    load_s       = 1'b1;
                    load_val_s   = LD_STOP;
                end else if (zero_s) begin
                    next_state_s = ST_READY;
                end else begin
                    next_state_s = ST_RST;
                end
            end
            ST_READY: begin
                if (!en) begin
                    next_state_s = ST_STOP;
                    load_s       = 1'b1;
                    load_val_s   = LD_STOP;
                end else begin
                    next_state_s = ST_READY;
                end
            end
            ST_STOP: begin
                // Shutdown always completes; a new request is served from OFF
                if (zero_s) begin
                    next_state_s = ST_OFF;
                end else begin
                    next_state_s = ST_STOP;
                end
            end
            default: begin
                next_state_s = ST_OFF;
            end
        endcase
    end

    // Outputs are decoded from the next state so every pin moves on the state edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_OFF;
            clk_ce       <= 1'b0;
            sensor_rst_n <= 1'b0;
            sensor_ready <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            clk_ce       <= st_clk_ce(next_state_s);
            sensor_rst_n <= st_rst_n(next_state_s);
            sensor_ready <= st_ready(next_state_s);
            busy         <= st_busy(next_state_s);
        end
    end

    assign seq_state = state_r;

endmodule

// File: tb/tb_sensor_pwr_seq.sv
// Directed and randomized bench for sensor_pwr_seq against a phase/age reference
// model; runs a short-timing instance and an all-T=1 instance side by side.
module tb_sensor_pwr_seq;

    logic       clk;
    logic       rst;
    logic       en;
    logic       ce_a, rn_a, rd_a, bz_a;
    logic [2:0] st_a;
    logic       ce_b, rn_b, rd_b, bz_b;
    logic [2:0] st_b;

    int n_vec = 0;
    int n_err = 0;
    int e;

    sensor_pwr_seq #(
        .T_PWR(4), .T_CLK2RST(3), .T_RST2RDY(5), .T_STOP(2), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .clk_ce(ce_a), .sensor_rst_n(rn_a), .sensor_ready(rd_a),
        .busy(bz_a), .seq_state(st_a)
    );

    sensor_pwr_seq #(
        .T_PWR(1), .T_CLK2RST(1), .T_RST2RDY(1), .T_STOP(1), .CNT_W(16)
    ) dut1 (
        .clk(clk), .rst(rst), .en(en),
        .clk_ce(ce_b), .sensor_rst_n(rn_b), .sensor_ready(rd_b),
        .busy(bz_b), .seq_state(st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a phase plus the number of cycles already spent in it
    typedef enum int {M_OFF = 0, M_PWR = 1, M_CLK = 2, M_RST = 3, M_READY = 4, M_STOP = 5} mph_t;
    mph_t ph [2];
    int   age[2];
    int   dur[2][6];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            ph[i]  = M_OFF;
            age[i] = 0;
        end
    endfunction

    function automatic void model_step(input int i);
        mph_t nx = ph[i];
        bit   done = (age[i] + 1 >= dur[i][int'(ph[i])]);
        if (rst) begin
            nx = M_OFF;
        end else begin
            case (ph[i])
                M_OFF:   if (en) nx = M_PWR;
                M_PWR:   nx = !en ? M_OFF  : (done ? M_CLK   : M_PWR);
                M_CLK:   nx = !en ? M_OFF  : (done ? M_RST   : M_CLK);
                M_RST:   nx = !en ? M_STOP : (done ? M_READY : M_RST);
                M_READY: if (!en) nx = M_STOP;
                M_STOP:  if (done) nx = M_OFF;
                default: nx = M_OFF;
            endcase
        end
        age[i] = (nx == ph[i]) ? age[i] + 1 : 0;
        ph[i]  = nx;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic check_model();
        logic [7:0] x_ce, x_rn, x_rd, x_bz;
        for (int i = 0; i < 2; i++) begin
            x_ce = (ph[i] == M_CLK || ph[i] == M_RST || ph[i] == M_READY || ph[i] == M_STOP) ? 8'd1 : 8'd0;
            x_rn = (ph[i] == M_RST || ph[i] == M_READY) ? 8'd1 : 8'd0;
            x_rd = (ph[i] == M_READY) ? 8'd1 : 8'd0;
            x_bz = (ph[i] == M_OFF || ph[i] == M_READY) ? 8'd0 : 8'd1;
            if (i == 0) begin
                chk("a_clk_ce", {7'd0, ce_a}, x_ce);
                chk("a_rst_n",  {7'd0, rn_a}, x_rn);
                chk("a_ready",  {7'd0, rd_a}, x_rd);
                chk("a_busy",   {7'd0, bz_a}, x_bz);
                chk("a_state",  {5'd0, st_a}, 8'(int'(ph[i])));
            end else begin
                chk("b_clk_ce", {7'd0, ce_b}, x_ce);
                chk("b_rst_n",  {7'd0, rn_b}, x_rn);
                chk("b_ready",  {7'd0, rd_b}, x_rd);
                chk("b_busy",   {7'd0, bz_b}, x_bz);
                chk("b_state",  {5'd0, st_b}, 8'(int'(ph[i])));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        e++;
        @(negedge clk);
        check_model();
    endtask

    initial begin
        dur[0] = '{1, 4, 3, 5, 1, 2};
        dur[1] = '{1, 1, 1, 1, 1, 1};
        model_reset();
        e   = -100;
        en  = 1'b0;
        rst = 1'b1;
        #1;
        chk("reset_ce",    {7'd0, ce_a}, 8'd0);
        chk("reset_rst_n", {7'd0, rn_a}, 8'd0);
        chk("reset_state", {5'd0, st_a}, 8'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Normal power-up, edge 0 is the first edge sampling en=1
        en = 1'b1;
        e  = -1;
        while (e < 19) begin
            tick();
            if (e == 3)  chk("up_ce_early", {7'd0, ce_a}, 8'd0);
            if (e == 4)  chk("up_ce",       {7'd0, ce_a}, 8'd1);
            if (e == 6)  chk("up_rn_early", {7'd0, rn_a}, 8'd0);
            if (e == 7)  chk("up_rn",       {7'd0, rn_a}, 8'd1);
            if (e == 11) chk("up_busy11",   {7'd0, bz_a}, 8'd1);
            if (e == 12) chk("up_ready",    {7'd0, rd_a}, 8'd1);
            if (e == 12) chk("up_busy12",   {7'd0, bz_a}, 8'd0);
            if (e == 1)  chk("t1_ce",       {7'd0, ce_b}, 8'd1);
            if (e == 2)  chk("t1_rn",       {7'd0, rn_b}, 8'd1);
            if (e == 3)  chk("t1_ready",    {7'd0, rd_b}, 8'd1);
        end

        // Shutdown at edge 20 with en back high at edge 21
        en = 1'b0;
        tick();
        chk("dn_ready", {7'd0, rd_a}, 8'd0);
        chk("dn_rn",    {7'd0, rn_a}, 8'd0);
        chk("dn_stop",  {5'd0, st_a}, 8'd5);
        en = 1'b1;
        tick();
        chk("dn_ce21", {7'd0, ce_a}, 8'd1);
        tick();
        chk("dn_ce22",  {7'd0, ce_a}, 8'd0);
        chk("dn_off22", {5'd0, st_a}, 8'd0);
        tick();
        chk("re_pwr23", {5'd0, st_a}, 8'd1);
        while (e < 27) begin
            tick();
            if (e == 26) chk("re_ce26", {7'd0, ce_a}, 8'd0);
            if (e == 27) chk("re_ce27", {7'd0, ce_a}, 8'd1);
        end

        en = 1'b0;
        repeat (10) tick();
        chk("idle_off", {5'd0, st_a}, 8'd0);

        // Abort in CLK: en low first sampled at edge 6
        en = 1'b1;
        e  = -1;
        while (e < 5) tick();
        chk("ab_clk5", {5'd0, st_a}, 8'd2);
        en = 1'b0;
        tick();
        chk("ab_off6", {5'd0, st_a}, 8'd0);
        chk("ab_ce6",  {7'd0, ce_a}, 8'd0);
        while (e < 15) begin
            tick();
            chk("ab_rn_low", {7'd0, rn_a}, 8'd0);
        end

        // Asynchronous reset half a cycle after edge 9 (in RST)
        en = 1'b1;
        e  = -1;
        while (e < 9) tick();
        chk("ar_rst9", {5'd0, st_a}, 8'd3);
        rst = 1'b1;
        #1;
        model_reset();
        chk("ar_ce",    {7'd0, ce_a}, 8'd0);
        chk("ar_rn",    {7'd0, rn_a}, 8'd0);
        chk("ar_ready", {7'd0, rd_a}, 8'd0);
        chk("ar_busy",  {7'd0, bz_a}, 8'd0);
        chk("ar_state", {5'd0, st_a}, 8'd0);
        tick();
        rst = 1'b0;
        e   = -1;
        while (e < 12) begin
            tick();
            if (e == 0)  chk("ar_pwr0",  {5'd0, st_a}, 8'd1);
            if (e == 4)  chk("ar_ce4",   {7'd0, ce_a}, 8'd1);
            if (e == 7)  chk("ar_rn7",   {7'd0, rn_a}, 8'd1);
            if (e == 12) chk("ar_rdy12", {7'd0, rd_a}, 8'd1);
        end

        // Randomized en levels with occasional synchronous-looking reset pulses
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 7) == 0) en = ~en;
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;
        en  = 1'b0;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
